ula_sequencer: RTL
==================

# ula_sequencer

Control FSM that sequences the ALU operation block (operand registers, 4-bit ALU select, compare flag, overflow register) for one stack-machine arithmetic, unary or compare operation. It accepts an opcode from the instruction decoder, pops operands from the data stack into the operand registers, fires the ALU, and then either pushes the result or loads the compare flag. It reports completion or stack underflow back to the decoder.

## Interface
- ADDR_WIDTH, 12: width of the stack depth count (`tos_in`).
- SEL_WIDTH, 4: width of the opcode and ALU select.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- opcode  in  SEL_WIDTH  operation code. 0–7 binary arithmetic; 8–9 unary; A–F compare.
- tos_in  in  ADDR_WIDTH  current number of entries on the data stack.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  underflow flag; valid only while `done`=1, 0 otherwise.
- stack_rd_en  out  1  read the top stack entry; data is valid on the next cycle.
- tos_dec  out  1  decrement the TOS register.
- stack_wr_en  out  1  write the ALU result to the stack.
- tos_inc  out  1  increment the TOS register.
- sel_mux_stack  out  2  stack write mux select: 2'b01 selects the ALU result; 2'b00 otherwise.
- ctrl_reg_op1  out  1  load operand register 1 from the stack output.
- ctrl_reg_op2  out  1  load operand register 2 from the stack output.
- ctrl_stack_comp  out  1  load the compare flag from the ALU.
- ctrl_reg_overflow  out  1  load the overflow register.
- sel_ula  out  SEL_WIDTH  ALU select.

## Operation
- States: IDLE, POP1, LOAD1, POP2, LOAD2, EXEC, PUSH, DONE.
- All outputs are registered or decoded from state. Every strobe is 0 outside the states listed below.
- **IDLE**
  - On `start`=1, latch `opcode` into `op_q`.
  - Required depth: 2 for binary or compare ops, 1 for unary ops.
  - If `tos_in` is below the required depth, go to DONE with `err_q`=1.
  - Otherwise go to POP1.
- **POP1**: assert `stack_rd_en` and `tos_dec`.
- **LOAD1**
  - Binary and compare ops: assert `ctrl_reg_op2` (the top of stack is the right-hand operand); go to POP2.
  - Unary ops: assert `ctrl_reg_op1`; go to EXEC.
- **POP2**: assert `stack_rd_en` and `tos_dec`.
- **LOAD2**: assert `ctrl_reg_op1`.
- **EXEC**
  - The ALU settles in this state.
  - Compare ops: assert `ctrl_stack_comp`; go to DONE.
  - Other ops: go to PUSH.
- **PUSH**: assert `stack_wr_en`, `tos_inc`, `ctrl_reg_overflow`, and `sel_mux_stack`=2'b01.
- **DONE**: assert `done` and drive `err` from `err_q`; return to IDLE.
- `sel_ula` = `op_q` from POP1 through DONE; 0 in IDLE.
- Net TOS change per op:
  - binary: −1
  - unary: 0
  - compare: −2
  - underflow: 0, with no strobes issued at all.
- `start` while busy is ignored and not queued.
- Opcode and `tos_in` are sampled only on the accepting edge; later changes to them have no effect.

## Timing
- Reset (asynchronous, active-low): state = IDLE, `op_q`=0, `err_q`=0, and all outputs 0. This holds even mid-operation; a partial pop is not undone, and the decoder must reset the datapath alongside.
- Latency counts from the accepting edge k to the cycle in which `done`=1:
  - binary: k+7
  - unary: k+5
  - compare: k+6
  - underflow: k+1
- `busy` rises in cycle k+1 and falls when returning to IDLE after DONE.
- The earliest next `start` is accepted in the cycle after DONE; back-to-back ops have no idle gap beyond that.
- Stack read latency is 1 cycle: data read in POP*n* is loaded in LOAD*n*.

## Test plan
- **Reset:** assert reset mid-PUSH with opcode 3 → all outputs 0 immediately (asynchronously); state IDLE; no `done` pulse.
- **Binary op:** `tos_in`=5, opcode 2, `start` at edge k → POP1/LOAD1(op2)/POP2/LOAD2(op1)/EXEC/PUSH strobes in cycles k+1..k+6; `done`=1, `err`=0 at k+7; `sel_ula`=2 during k+1..k+7.
- **Unary op:** `tos_in`=1, opcode 9 → `ctrl_reg_op1` at k+2; PUSH at k+4; `done` at k+5; exactly one `tos_dec` and one `tos_inc`.
- **Compare op:** `tos_in`=2, opcode C → `ctrl_stack_comp` at k+5; no `stack_wr_en`; `done` at k+6; two `tos_dec`.
- **Underflow:** `tos_in`=1, opcode 0 → `done`=1 and `err`=1 at k+1; zero strobes. Then `tos_in`=0, opcode 8 → same response.
- **Start while busy:** `start` pulses during k+2..k+6 of a binary op → ignored; exactly one `done`. A `start` in the cycle after DONE is accepted.

Source files
------------

// File: rtl/ula_sequencer_if.sv
// Decoder <-> ALU sequencer bundle: request/opcode/depth in, status and datapath strobes out.
// The master side is the instruction decoder; the slave side is ula_sequencer.
interface ula_sequencer_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int SEL_WIDTH  = 4
);
    logic                  start;
    logic [SEL_WIDTH-1:0]  opcode;
    logic [ADDR_WIDTH-1:0] tos_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  stack_rd_en;
    logic                  tos_dec;
    logic                  stack_wr_en;
    logic                  tos_inc;
    logic [1:0]            sel_mux_stack;
    logic                  ctrl_reg_op1;
    logic                  ctrl_reg_op2;
    logic                  ctrl_stack_comp;
    logic                  ctrl_reg_overflow;
    logic [SEL_WIDTH-1:0]  sel_ula;

    modport master (
        output start, opcode, tos_in,
        input  busy, done, err, stack_rd_en, tos_dec, stack_wr_en, tos_inc,
        input  sel_mux_stack, ctrl_reg_op1, ctrl_reg_op2, ctrl_stack_comp,
        input  ctrl_reg_overflow, sel_ula
    );

    modport slave (
        input  start, opcode, tos_in,
        output busy, done, err, stack_rd_en, tos_dec, stack_wr_en, tos_inc,
        output sel_mux_stack, ctrl_reg_op1, ctrl_reg_op2, ctrl_stack_comp,
        output ctrl_reg_overflow, sel_ula
    );
endinterface

// File: rtl/ula_sequencer.sv
// Control FSM for one stack-machine ALU operation: pop operands, fire the ALU, then push
// the result or load the compare flag. All outputs are decoded from the registered state.
module ula_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int SEL_WIDTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ula_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_POP1,
        S_LOAD1,
        S_POP2,
        S_LOAD2,
        S_EXEC,
        S_PUSH,
        S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [SEL_WIDTH-1:0] op_reg, op_next;
    logic                 err_reg, err_next;

    // Opcode classes: 0-7 binary, 8-9 unary, A-F compare.
    function automatic logic is_unary(input logic [SEL_WIDTH-1:0] op);
        return (op >= SEL_WIDTH'(8)) && (op <= SEL_WIDTH'(9));
    endfunction

    function automatic logic is_compare(input logic [SEL_WIDTH-1:0] op);
        return op >= SEL_WIDTH'(10);
    endfunction

    logic [ADDR_WIDTH-1:0] need_depth;
    assign need_depth = is_unary(bus.opcode) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    op_next = bus.opcode;
                    if (bus.tos_in < need_depth) begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        err_next   = 1'b0;
                        state_next = S_POP1;
                    end
                end
            end
            S_POP1:  state_next = S_LOAD1;
            S_LOAD1: state_next = is_unary(op_reg) ? S_EXEC : S_POP2;
            S_POP2:  state_next = S_LOAD2;
            S_LOAD2: state_next = S_EXEC;
            S_EXEC:  state_next = is_compare(op_reg) ? S_DONE : S_PUSH;
            S_PUSH:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    logic                 busy_c, done_c, err_c, rd_c, dec_c, wr_c, inc_c;
    logic [1:0]           mux_c;
    logic                 op1_c, op2_c, comp_c, ovf_c;
    logic [SEL_WIDTH-1:0] sel_c;

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        err_c  = 1'b0;
        rd_c   = 1'b0;
        dec_c  = 1'b0;
        wr_c   = 1'b0;
        inc_c  = 1'b0;
        mux_c  = 2'b00;
        op1_c  = 1'b0;
        op2_c  = 1'b0;
        comp_c = 1'b0;
        ovf_c  = 1'b0;
        sel_c  = '0;
        if (state_reg != S_IDLE) begin
            busy_c = 1'b1;
            sel_c  = op_reg;
        end
        case (state_reg)
            S_POP1, S_POP2: begin
                rd_c  = 1'b1;
                dec_c = 1'b1;
            end
            // First pop returns the top of stack, which is the right-hand operand.
            S_LOAD1: begin
                if (is_unary(op_reg)) op1_c = 1'b1;
                else                  op2_c = 1'b1;
            end
            S_LOAD2: op1_c  = 1'b1;
            S_EXEC:  comp_c = is_compare(op_reg);
            S_PUSH: begin
                wr_c  = 1'b1;
                inc_c = 1'b1;
                ovf_c = 1'b1;
                mux_c = 2'b01;
            end
            S_DONE: begin
                done_c = 1'b1;
                err_c  = err_reg;
            end
            default: ;
        endcase
    end

    assign bus.busy              = busy_c;
    assign bus.done              = done_c;
    assign bus.err               = err_c;
    assign bus.stack_rd_en       = rd_c;
    assign bus.tos_dec           = dec_c;
    assign bus.stack_wr_en       = wr_c;
    assign bus.tos_inc           = inc_c;
    assign bus.sel_mux_stack     = mux_c;
    assign bus.ctrl_reg_op1      = op1_c;
    assign bus.ctrl_reg_op2      = op2_c;
    assign bus.ctrl_stack_comp   = comp_c;
    assign bus.ctrl_reg_overflow = ovf_c;
    assign bus.sel_ula           = sel_c;
endmodule
